// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the receive path.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

   localparam int UART_DATA_W   = 16;
   localparam int UART_RX_DEPTH = 16;

   // One received frame as stored in the receive FIFO.
   typedef struct packed {
      logic                   err;
      logic [UART_DATA_W-1:0] data;
   } uart_rx_entry_t;

endpackage

// File: rtl/uart_rx_buf_if.sv
// Frame capture and read-drain signals of the UART receive buffer.
// Latency: wires only; timing is set by the module behind the slave modport.
// Backpressure: rd_ready_i holds the head entry; the capture side cannot be stalled.
interface uart_rx_buf_if;
   import uart_pkg::*;

   logic                   rx_done_i;
   logic [UART_DATA_W-1:0] rx_data_i;
   logic                   rx_err_i;
   logic                   rd_ready_i;
   logic                   rd_valid_o;
   logic [UART_DATA_W-1:0] rd_data_o;
   logic                   rd_err_o;

   // Receiver and bus-side consumer.
   modport master (
      output rx_done_i, rx_data_i, rx_err_i, rd_ready_i,
      input  rd_valid_o, rd_data_o, rd_err_o
   );

   // The buffer itself.
   modport slave (
      input  rx_done_i, rx_data_i, rx_err_i, rd_ready_i,
      output rd_valid_o, rd_data_o, rd_err_o
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers, show-ahead read port.
// Latency: a write is visible at the head one cycle after its edge; reads advance per edge.
// Backpressure: caller must not write when full without a same-cycle read; empty reads ignored.
module uart_sync_fifo #(
   parameter type T     = logic,
   parameter int  DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   wr_en,
   input  T                       wr_dat,
   input  logic                   rd_en,
   input  logic                   flush,
   output T                       rd_dat,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   T            mem [DEPTH];

   // Pointer update; flush wins over any write or read in the same cycle.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en)
            wptr <= wptr + 1'b1;
         if (rd_en && !empty)
            rptr <= rptr + 1'b1;
      end
   end

   // Storage is not reset; unread slots are never exposed to the consumer.
   always_ff @(posedge clk) begin
      if (wr_en && !flush)
         mem[wptr[AW-1:0]] <= wr_dat;
   end

   assign rd_dat = mem[rptr[AW-1:0]];
   assign empty  = (wptr == rptr);
   assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign level  = wptr - rptr;

endmodule

// File: rtl/uart_rx_buf.sv
// UART receive buffer: one FIFO push per frame-done rise, status flags and interrupts.
// Latency: a frame sampled at edge N is at the head after N; pops show the next head after the edge.
// Backpressure: rd_ready_i gates pops; a frame arriving while full without a pop is dropped and sets ovf_o.
// Optional idle-data timeout interrupt is built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_buf
   import uart_pkg::*;
#(
   parameter int DEPTH       = UART_RX_DEPTH,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                   clk,
   input  logic                   rstn,
   uart_rx_buf_if.slave           bus,
   input  logic                   flush_i,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   full_o,
   output logic                   empty_o,
   input  logic [$clog2(DEPTH):0] thresh_i,
   output logic                   thresh_irq_o,
   output logic                   ovf_o,
   input  logic                   ovf_clr_i,
   output logic                   timeout_irq_o
);

   localparam int LW = $clog2(DEPTH) + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_buf: DEPTH must be a power of two and at least 2");
   end
   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("uart_rx_buf: TIMEOUT_CYC must be at least 2");
   end

   logic           rx_done_q;
   logic           push;
   logic           rd_en;
   logic           wr_en;
   logic           ovf_set;
   logic [LW-1:0]  thresh_q;
   logic [LW-1:0]  level;
   logic           full;
   logic           empty;
   uart_rx_entry_t wr_entry;
   uart_rx_entry_t head;

   // Done-level history; reset high so a level held through reset is not a new frame.
   always_ff @(posedge clk) begin
      if (!rstn)
         rx_done_q <= 1'b1;
      else
         rx_done_q <= bus.rx_done_i;
   end

   assign push  = bus.rx_done_i & ~rx_done_q;
   assign rd_en = bus.rd_ready_i & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign wr_en = push & (~full | rd_en) & ~flush_i;
   assign ovf_set = push & full & ~rd_en & ~flush_i;

   assign wr_entry.err  = bus.rx_err_i;
   assign wr_entry.data = bus.rx_data_i;

   uart_sync_fifo #(
      .T     (uart_rx_entry_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rstn   (rstn),
      .wr_en  (wr_en),
      .wr_dat (wr_entry),
      .rd_en  (rd_en),
      .flush  (flush_i),
      .rd_dat (head),
      .full   (full),
      .empty  (empty),
      .level  (level)
   );

   // Sticky overflow; a new overflow in the clear cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (!rstn)
         ovf_o <= 1'b0;
      else if (ovf_set)
         ovf_o <= 1'b1;
      else if (ovf_clr_i)
         ovf_o <= 1'b0;
   end

   // Threshold is registered so the interrupt depends on state only, never on a live input.
   always_ff @(posedge clk) begin
      if (!rstn)
         thresh_q <= '0;
      else
         thresh_q <= thresh_i;
   end

   assign thresh_irq_o = (thresh_q != '0) && (level >= thresh_q);

   assign level_o        = level;
   assign full_o         = full;
   assign empty_o        = empty;
   assign bus.rd_valid_o = ~empty;
   // Head is forced to zero while empty so stale or uninitialised storage never leaks out.
   assign bus.rd_data_o  = empty ? '0 : head.data;
   assign bus.rd_err_o   = ~empty & head.err;

`ifdef UART_RX_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC);

   logic [CW-1:0] to_cnt;
   logic          to_irq;

   // Idle counter over non-empty cycles; any FIFO activity restarts it and drops the interrupt.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         to_cnt <= '0;
         to_irq <= 1'b0;
      end else if (wr_en || rd_en || flush_i) begin
         to_cnt <= '0;
         to_irq <= 1'b0;
      end else if (level != '0) begin
         if (to_cnt == CW'(TIMEOUT_CYC - 1))
            to_irq <= 1'b1;
         else
            to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timeout_irq_o = to_irq;
`else
   assign timeout_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf: directed scenarios plus randomized traffic vs a queue model.
// Latency: model updates on each rising edge; DUT outputs are compared on every falling edge.
// Backpressure: rd_ready is driven both steadily and randomly to exercise full/overflow paths.
module tb_uart_rx_buf;

   localparam int DEPTH = 16;
   localparam int TOC   = 64;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rstn;
   logic          flush;
   logic          ovf_clr;
   logic [LW-1:0] thresh;
   logic [LW-1:0] level;
   logic          full;
   logic          empty;
   logic          thresh_irq;
   logic          ovf;
   logic          timeout_irq;

   int checks = 0;
   int passed = 0;

   uart_rx_buf_if bus ();

   uart_rx_buf #(.DEPTH(DEPTH), .TIMEOUT_CYC(TOC)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .bus           (bus),
      .flush_i       (flush),
      .level_o       (level),
      .full_o        (full),
      .empty_o       (empty),
      .thresh_i      (thresh),
      .thresh_irq_o  (thresh_irq),
      .ovf_o         (ovf),
      .ovf_clr_i     (ovf_clr),
      .timeout_irq_o (timeout_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp)
         passed++;
      else
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [16:0] mq[$];
   bit          m_done_prev;
   bit          m_ovf;
   int          m_thresh;
   bit          m_live = 0;

   always @(posedge clk) begin
      if (!rstn) begin
         mq.delete();
         m_done_prev = 1'b1;
         m_ovf       = 1'b0;
         m_thresh    = 0;
         m_live      = 1'b1;
      end else begin
         bit new_frame, do_pop, was_full, ovf_now;
         new_frame   = bus.rx_done_i && !m_done_prev;
         m_done_prev = bus.rx_done_i;
         do_pop      = bus.rd_ready_i && (mq.size() > 0);
         was_full    = (mq.size() == DEPTH);
         ovf_now     = 1'b0;
         if (flush) begin
            mq.delete();
         end else begin
            if (do_pop)
               void'(mq.pop_front());
            if (new_frame) begin
               if (was_full && !do_pop)
                  ovf_now = 1'b1;
               else
                  mq.push_back({bus.rx_err_i, bus.rx_data_i});
            end
         end
         if (ovf_now)
            m_ovf = 1'b1;
         else if (ovf_clr)
            m_ovf = 1'b0;
         m_thresh = int'(thresh);
      end
   end

   // One compare process over every cycle once the model has seen reset.
   always @(negedge clk) begin
      if (m_live) begin
         int n;
         n = mq.size();
         chk("m_rd_valid", int'(bus.rd_valid_o), int'(n > 0));
         chk("m_level",    int'(level),          n);
         chk("m_empty",    int'(empty),          int'(n == 0));
         chk("m_full",     int'(full),           int'(n == DEPTH));
         chk("m_ovf",      int'(ovf),            int'(m_ovf));
         chk("m_thresh_irq", int'(thresh_irq),   int'(m_thresh != 0 && n >= m_thresh));
         if (n > 0) begin
            chk("m_rd_data", int'(bus.rd_data_o), int'(mq[0][15:0]));
            chk("m_rd_err",  int'(bus.rd_err_o),  int'(mq[0][16]));
         end
`ifndef UART_RX_TIMEOUT_EN
         chk("m_timeout_irq", int'(timeout_irq), 0);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [15:0] d, input logic e);
      bus.rx_done_i = 1'b1;
      bus.rx_data_i = d;
      bus.rx_err_i  = e;
      tick();
      bus.rx_done_i = 1'b0;
      tick();
   endtask

   task automatic pop1();
      bus.rd_ready_i = 1'b1;
      tick();
      bus.rd_ready_i = 1'b0;
   endtask

   initial begin
      logic [15:0] last;
      bit          ovf_before;
      bus.rx_done_i  = 1'b1;
      bus.rx_data_i  = 16'h0;
      bus.rx_err_i   = 1'b0;
      bus.rd_ready_i = 1'b0;
      flush   = 1'b0;
      ovf_clr = 1'b0;
      thresh  = '0;
      rstn    = 1'b0;

      // Reset with done held high.
      repeat (3) tick();
      chk("rst_rd_valid", int'(bus.rd_valid_o), 0);
      chk("rst_level",    int'(level), 0);
      chk("rst_empty",    int'(empty), 1);
      chk("rst_full",     int'(full), 0);
      chk("rst_ovf",      int'(ovf), 0);
      chk("rst_thresh_irq", int'(thresh_irq), 0);
      chk("rst_timeout_irq", int'(timeout_irq), 0);
      chk("rst_rd_data",  int'(bus.rd_data_o), 0);
      chk("rst_rd_err",   int'(bus.rd_err_o), 0);
      rstn = 1'b1;
      repeat (3) tick();
      chk("held_done_no_push", int'(level), 0);
      bus.rx_done_i = 1'b0;
      tick();
      frame(16'h00A5, 1'b0);
      chk("first_level", int'(level), 1);
      chk("first_data",  int'(bus.rd_data_o), 16'h00A5);
      chk("first_err",   int'(bus.rd_err_o), 0);
      pop1();
      chk("first_drained", int'(empty), 1);

      // Fill, overflow, drain in order, clear.
      for (int i = 0; i < DEPTH; i++) frame(16'(i), 1'(i & 1));
      frame(16'h0BAD, 1'b0);
      chk("ovf_full",  int'(full), 1);
      chk("ovf_set",   int'(ovf), 1);
      chk("ovf_level", int'(level), 16);
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_order", int'(bus.rd_data_o), i);
         pop1();
      end
      chk("drain_empty", int'(empty), 1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("ovf_cleared", int'(ovf), 0);

      // Full with simultaneous push and pop.
      for (int i = 0; i < DEPTH; i++) frame(16'h0100 + 16'(i), 1'b0);
      bus.rx_done_i  = 1'b1;
      bus.rx_data_i  = 16'h1234;
      bus.rd_ready_i = 1'b1;
      tick();
      bus.rx_done_i  = 1'b0;
      bus.rd_ready_i = 1'b0;
      chk("pp_ovf",   int'(ovf), 0);
      chk("pp_level", int'(level), 16);
      chk("pp_head",  int'(bus.rd_data_o), 16'h0101);
      last = 16'h0;
      for (int i = 0; i < DEPTH; i++) begin
         last = bus.rd_data_o;
         pop1();
      end
      chk("pp_last", int'(last), 16'h1234);

      // Threshold interrupt.
      thresh = LW'(4);
      tick();
      for (int i = 0; i < 3; i++) frame(16'h0200 + 16'(i), 1'b1);
      chk("thr_below", int'(thresh_irq), 0);
      frame(16'h0203, 1'b0);
      chk("thr_at", int'(thresh_irq), 1);
      pop1();
      chk("thr_after_pop", int'(thresh_irq), 0);
      repeat (3) pop1();
      thresh = '0;
      tick();
      for (int i = 0; i < 5; i++) frame(16'h0300 + 16'(i), 1'b0);
      chk("thr_zero", int'(thresh_irq), 0);

      // Flush with simultaneous push and pop.
      ovf_before = ovf;
      flush = 1'b1;
      bus.rx_done_i  = 1'b1;
      bus.rx_data_i  = 16'h0777;
      bus.rd_ready_i = 1'b1;
      tick();
      flush = 1'b0;
      bus.rx_done_i  = 1'b0;
      bus.rd_ready_i = 1'b0;
      chk("flush_level", int'(level), 0);
      chk("flush_empty", int'(empty), 1);
      chk("flush_ovf",   int'(ovf), int'(ovf_before));
      tick();

      // Idle-data timeout.
      bus.rx_done_i = 1'b1;
      bus.rx_data_i = 16'h0042;
      tick();
      bus.rx_done_i = 1'b0;
      repeat (TOC - 1) tick();
      chk("to_before", int'(timeout_irq), 0);
      tick();
`ifdef UART_RX_TIMEOUT_EN
      chk("to_fire", int'(timeout_irq), 1);
      repeat (5) tick();
      chk("to_sticky", int'(timeout_irq), 1);
`else
      chk("to_off", int'(timeout_irq), 0);
      repeat (5) tick();
`endif
      pop1();
      chk("to_cleared", int'(timeout_irq), 0);

      // Randomized traffic, checked per cycle by the model.
      for (int c = 0; c < 3000; c++) begin
         int rd_pct;
         rd_pct = ((c / 400) % 2 == 0) ? 15 : 80;
         if (!bus.rx_done_i) begin
            if ($urandom_range(2) == 0) begin
               bus.rx_done_i = 1'b1;
               bus.rx_data_i = 16'($urandom);
               bus.rx_err_i  = 1'($urandom);
            end
         end else if ($urandom_range(1) == 0) begin
            bus.rx_done_i = 1'b0;
         end
         bus.rd_ready_i = ($urandom_range(99) < rd_pct);
         flush   = ($urandom_range(249) == 0);
         ovf_clr = ($urandom_range(29) == 0);
         if ($urandom_range(49) == 0)
            thresh = LW'($urandom_range(DEPTH));
         tick();
      end
      bus.rx_done_i  = 1'b0;
      bus.rd_ready_i = 1'b0;
      flush   = 1'b0;
      ovf_clr = 1'b0;
      repeat (2) tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
